// File: rtl/spec_reg_stack.sv
// Status register (N/Z/C/V, mode, is_bios) with a LIFO save stack for nested traps.
// Optional saturating trap counter enabled by defining SPECREG_TRAP_COUNT_EN.
module spec_reg_stack #(
    parameter int MODE_W = 2,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [3:0]          update_mode,
    input  logic                alu_negative,
    input  logic                alu_zero,
    input  logic                alu_carry,
    input  logic                alu_overflow,
    input  logic                bs_negative,
    input  logic                bs_zero,
    input  logic                bs_carry,
    input  logic [MODE_W-1:0]   trap_mode,
    input  logic [MODE_W+3:0]   wr_data,
    input  logic [MODE_W+3:0]   wr_mask,
    output logic                negative_flag,
    output logic                zero_flag,
    output logic                carry_flag,
    output logic                overflow_flag,
    output logic [MODE_W-1:0]   mode,
    output logic                is_bios,
    output logic [CNT_W-1:0]    depth_count,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                stack_fault,
    output logic [7:0]          trap_count
);

    localparam int ENT_W = MODE_W + 5;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [3:0] CMD_BS    = 4'd1;
    localparam logic [3:0] CMD_ADD   = 4'd2;
    localparam logic [3:0] CMD_MOV   = 4'd3;
    localparam logic [3:0] CMD_OVF   = 4'd4;
    localparam logic [3:0] CMD_TRAP  = 4'd5;
    localparam logic [3:0] CMD_RET   = 4'd6;
    localparam logic [3:0] CMD_WRITE = 4'd7;

    logic [ENT_W-1:0]  stack_mem [DEPTH];
    logic [ENT_W-1:0]  push_entry;
    logic [ENT_W-1:0]  top_entry;
    logic [CNT_W-1:0]  depth_dec;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic [MODE_W+3:0] cur_word;
    logic [MODE_W+3:0] wr_word;
    logic              do_trap;

    // Entry layout {N,Z,C,V,mode,is_bios}; push slot is depth_count, top is one below
    assign push_entry  = {negative_flag, zero_flag, carry_flag,
                          overflow_flag, mode, is_bios};
    assign depth_dec   = depth_count - CNT_W'(1);
    assign push_idx    = depth_count[IDX_W-1:0];
    assign top_idx     = depth_dec[IDX_W-1:0];
    assign top_entry   = stack_mem[top_idx];

    assign stack_full  = (depth_count == CNT_W'(DEPTH));
    assign stack_empty = (depth_count == '0);

    assign do_trap     = enable && (update_mode == CMD_TRAP);

    assign cur_word    = {negative_flag, zero_flag, carry_flag,
                          overflow_flag, mode};
    assign wr_word     = (cur_word & ~wr_mask) | (wr_data & wr_mask);

    // Save-stack storage; contents are not reset, only the depth pointer is
    always_ff @(posedge clock) begin
        if (reset && do_trap && !stack_full) begin
            stack_mem[push_idx] <= push_entry;
        end
    end

    // Flag/mode/context state machine with reset taking priority over commands
    always_ff @(posedge clock) begin
        if (!reset) begin
            negative_flag <= 1'b0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            mode          <= '0;
            is_bios       <= 1'b1;
            depth_count   <= '0;
            stack_fault   <= 1'b0;
        end else if (enable) begin
            case (update_mode)
                CMD_BS: begin
                    negative_flag <= bs_negative;
                    zero_flag     <= bs_zero;
                    carry_flag    <= bs_carry;
                end
                CMD_ADD: begin
                    negative_flag <= alu_negative;
                    zero_flag     <= alu_zero;
                    carry_flag    <= alu_carry;
                    overflow_flag <= alu_overflow;
                end
                CMD_MOV: begin
                    negative_flag <= alu_negative;
                    zero_flag     <= alu_zero;
                end
                CMD_OVF: begin
                    overflow_flag <= alu_overflow;
                end
                CMD_TRAP: begin
                    mode    <= trap_mode;
                    is_bios <= 1'b0;
                    if (stack_full) begin
                        stack_fault <= 1'b1;
                    end else begin
                        depth_count <= depth_count + CNT_W'(1);
                    end
                end
                CMD_RET: begin
                    if (stack_empty) begin
                        stack_fault <= 1'b1;
                    end else begin
                        {negative_flag, zero_flag, carry_flag,
                         overflow_flag, mode, is_bios} <= top_entry;
                        depth_count <= depth_dec;
                    end
                end
                CMD_WRITE: begin
                    {negative_flag, zero_flag, carry_flag,
                     overflow_flag, mode} <= wr_word;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SPECREG_TRAP_COUNT_EN
    logic [7:0] trap_cnt_q;

    // Saturating count of every trap command, faulting ones included
    always_ff @(posedge clock) begin
        if (!reset) begin
            trap_cnt_q <= 8'h00;
        end else if (do_trap && (trap_cnt_q != 8'hFF)) begin
            trap_cnt_q <= trap_cnt_q + 8'h01;
        end
    end

    assign trap_count = trap_cnt_q;
`else
    assign trap_count = 8'h00;
`endif

endmodule

// File: tb/tb_spec_reg_stack.sv
// Self-checking bench for spec_reg_stack (MODE_W=2, DEPTH=4).
// Reference model drives a scoreboard queue compared after each clock edge.
module tb_spec_reg_stack;

    typedef struct packed {
        logic [3:0] f;
        logic [1:0] m;
        logic       b;
        logic [2:0] d;
        logic       full;
        logic       empty;
        logic       fault;
        logic [7:0] tc;
    } st_t;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] update_mode;
    logic       alu_negative, alu_zero, alu_carry, alu_overflow;
    logic       bs_negative, bs_zero, bs_carry;
    logic [1:0] trap_mode;
    logic [5:0] wr_data;
    logic [5:0] wr_mask;
    logic       negative_flag, zero_flag, carry_flag, overflow_flag;
    logic [1:0] mode;
    logic       is_bios;
    logic [2:0] depth_count;
    logic       stack_full, stack_empty, stack_fault;
    logic [7:0] trap_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [3:0] m_f;
    logic [1:0] m_m;
    logic       m_b;
    logic       m_fault;
    logic [7:0] m_tc;
    logic [6:0] m_stk [$];
    st_t        sb [$];

    spec_reg_stack #(.MODE_W(2), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .update_mode(update_mode),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .bs_negative(bs_negative), .bs_zero(bs_zero), .bs_carry(bs_carry),
        .trap_mode(trap_mode), .wr_data(wr_data), .wr_mask(wr_mask),
        .negative_flag(negative_flag), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .overflow_flag(overflow_flag),
        .mode(mode), .is_bios(is_bios), .depth_count(depth_count),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .stack_fault(stack_fault), .trap_count(trap_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic st_t obs();
        st_t s;
        s.f     = {negative_flag, zero_flag, carry_flag, overflow_flag};
        s.m     = mode;
        s.b     = is_bios;
        s.d     = depth_count;
        s.full  = stack_full;
        s.empty = stack_empty;
        s.fault = stack_fault;
        s.tc    = trap_count;
        return s;
    endfunction

    function automatic st_t model_state();
        st_t s;
        s.f     = m_f;
        s.m     = m_m;
        s.b     = m_b;
        s.d     = 3'(m_stk.size());
        s.full  = (m_stk.size() == 4);
        s.empty = (m_stk.size() == 0);
        s.fault = m_fault;
        s.tc    = m_tc;
        return s;
    endfunction

    task automatic model_step(input logic e, input logic [3:0] c);
        logic [5:0] w;
        logic [6:0] ent;
        if (!e) return;
        case (c)
            4'd1: m_f[3:1] = {bs_negative, bs_zero, bs_carry};
            4'd2: m_f = {alu_negative, alu_zero, alu_carry, alu_overflow};
            4'd3: m_f[3:2] = {alu_negative, alu_zero};
            4'd4: m_f[0] = alu_overflow;
            4'd5: begin
`ifdef SPECREG_TRAP_COUNT_EN
                if (m_tc != 8'd255) m_tc = m_tc + 8'd1;
`endif
                if (m_stk.size() < 4) m_stk.push_back({m_f, m_m, m_b});
                else m_fault = 1'b1;
                m_m = trap_mode;
                m_b = 1'b0;
            end
            4'd6: begin
                if (m_stk.size() > 0) begin
                    ent = m_stk.pop_back();
                    m_f = ent[6:3];
                    m_m = ent[2:1];
                    m_b = ent[0];
                end else begin
                    m_fault = 1'b1;
                end
            end
            4'd7: begin
                w = ({m_f, m_m} & ~wr_mask) | (wr_data & wr_mask);
                m_f = w[5:2];
                m_m = w[1:0];
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic e, input logic [3:0] c,
                         input logic [3:0] alu, input logic [2:0] bs,
                         input logic [1:0] tm, input logic [5:0] wd,
                         input logic [5:0] wm);
        @(negedge clock);
        reset = 1'b1;
        enable = e;
        update_mode = c;
        {alu_negative, alu_zero, alu_carry, alu_overflow} = alu;
        {bs_negative, bs_zero, bs_carry} = bs;
        trap_mode = tm;
        wr_data = wd;
        wr_mask = wm;
        model_step(e, c);
        sb.push_back(model_state());
        @(posedge clock);
        #1;
    endtask

    // reset asserted while a trap command is also presented
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        enable = 1'b1;
        update_mode = 4'd5;
        trap_mode = 2'd3;
        m_f = 4'b0;
        m_m = 2'd0;
        m_b = 1'b1;
        m_fault = 1'b0;
        m_tc = 8'd0;
        m_stk.delete();
        sb.push_back(model_state());
        @(posedge clock);
        #1;
        reset = 1'b1;
        enable = 1'b0;
    endtask

    task automatic test_reset();
        st_t e, o;
        do_reset();
        e = sb.pop_front();
        o = obs();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset got %h exp %h", o, e);
        end
        checks++;
        if (o !== st_t'({4'b0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0})) begin
            errors++;
            $display("FAIL reset_const got %h", o);
        end
    endtask

    task automatic test_flags();
        st_t e, o;
        logic [3:0] want [6];
        want = '{4'b1011, 4'b0101, 4'b1001, 4'b1001, 4'b1000, 4'b1000};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(1, 4'd2, 4'b1011, 3'b000, 0, 0, 0);
                1: drive(1, 4'd1, 4'b0000, 3'b010, 0, 0, 0);
                2: drive(1, 4'd3, 4'b1000, 3'b111, 0, 0, 0);
                3: drive(0, 4'd2, 4'b0110, 3'b000, 0, 0, 0);
                4: drive(1, 4'd4, 4'b1110, 3'b111, 0, 0, 0);
                default: drive(1, 4'd11, 4'b0111, 3'b111, 3, 6'h3f, 6'h3f);
            endcase
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL flags_sb[%0d] got %h exp %h", i, o, e);
            end
            checks++;
            if (o.f !== want[i]) begin
                errors++;
                $display("FAIL flags[%0d] got %b exp %b", i, o.f, want[i]);
            end
        end
    endtask

    task automatic test_nested();
        st_t e, o;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(1, 4'd7, 0, 0, 0, 6'b1100_00, 6'b1111_11);
                1: drive(1, 4'd5, 0, 0, 2'd1, 0, 0);
                2: drive(1, 4'd7, 0, 0, 0, 6'b0011_00, 6'b1111_00);
                3: drive(1, 4'd5, 0, 0, 2'd2, 0, 0);
                4: drive(1, 4'd6, 0, 0, 0, 0, 0);
                default: drive(1, 4'd6, 0, 0, 0, 0, 0);
            endcase
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL nested_sb[%0d] got %h exp %h", i, o, e);
            end
            if (i == 4) begin
                checks++;
                if ({o.f, o.m, o.b, o.d} !== {4'b0011, 2'd1, 1'b0, 3'd1}) begin
                    errors++;
                    $display("FAIL nested_ret1 got %h", o);
                end
            end
            if (i == 5) begin
                checks++;
                if ({o.f, o.m, o.b, o.empty} !== {4'b1100, 2'd0, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL nested_ret2 got %h", o);
                end
            end
        end
    endtask

    task automatic test_overflow();
        st_t e, o, orig;
        orig = obs();
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'd5, 0, 0, 2'(i + 1), 0, 0);
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ovf_push[%0d] got %h exp %h", i, o, e);
            end
        end
        checks++;
        if ({o.d, o.full, o.fault} !== {3'd4, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_full got d=%0d full=%b fault=%b", o.d, o.full, o.fault);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'd6, 0, 0, 0, 0, 0);
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ovf_pop[%0d] got %h exp %h", i, o, e);
            end
        end
        checks++;
        if ({o.f, o.m, o.b, o.d} !== {orig.f, orig.m, orig.b, 3'd0}) begin
            errors++;
            $display("FAIL ovf_restore got %h exp %h", o, orig);
        end
    endtask

    task automatic test_underflow_write();
        st_t e, o;
        do_reset();
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(1, 4'd2, 4'b1010, 0, 0, 0, 0);
                1: drive(1, 4'd6, 4'b1111, 0, 0, 0, 0);
                default: drive(1, 4'd7, 0, 0, 0, 6'b1111_10, 6'b0100_11);
            endcase
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL undr_sb[%0d] got %h exp %h", i, o, e);
            end
        end
        checks++;
        if ({o.f, o.m, o.b, o.d, o.fault} !== {4'b1110, 2'd2, 1'b1, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL undr_write got %h", o);
        end
    endtask

    task automatic test_back_to_back();
        st_t e, o;
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)),
                  4'($urandom), 3'($urandom), 2'($urandom),
                  6'($urandom), 6'($urandom));
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b[%0d] got %h exp %h", i, o, e);
            end
        end
        for (int i = 0; i < 16; i++) begin
            drive(1, (i % 3 == 2) ? 4'd6 : 4'd5, 4'($urandom), 0,
                  2'(i), 0, 0);
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_tr[%0d] got %h exp %h", i, o, e);
            end
        end
    endtask

    task automatic test_reset_counter();
        st_t e, o;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd5, 0, 0, 2'd2, 0, 0);
            e = sb.pop_front();
        end
        do_reset();
        e = sb.pop_front();
        o = obs();
        checks++;
        if ({o.d, o.b, o.tc, o.fault} !== {3'd0, 1'b1, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got %h exp %h", o, e);
        end
        for (int i = 0; i < 300; i++) begin
            drive(1, 4'd5, 0, 0, 2'(i), 0, 0);
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL cnt[%0d] got %h exp %h", i, o, e);
            end
        end
        checks++;
`ifdef SPECREG_TRAP_COUNT_EN
        if (o.tc !== 8'd255) begin
            errors++;
            $display("FAIL cnt_sat got %0d exp 255", o.tc);
        end
`else
        if (o.tc !== 8'd0) begin
            errors++;
            $display("FAIL cnt_off got %0d exp 0", o.tc);
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        update_mode = 4'd0;
        {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0;
        {bs_negative, bs_zero, bs_carry} = 3'b0;
        trap_mode = 2'd0;
        wr_data = 6'd0;
        wr_mask = 6'd0;
        test_reset();
        test_flags();
        test_nested();
        test_overflow();
        test_underflow_write();
        test_back_to_back();
        test_reset_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spec_reg_stack.md
Name: spec_reg_stack

Overview:
Parametrised successor to the processor status register. Holds the N/Z/C/V condition flags, a MODE_W-bit execution mode and the is_bios bit. Adds a DEPTH-entry save stack so traps (SWI/IRQ) nest and return restores the full context. It sits in the control unit between the ALU/barrel-shifter flag outputs and the condition-evaluation/decode logic.

Parameters:
MODE_W, 2, width of the mode field (number of mode bits).
DEPTH, 4, number of save-stack entries (>=1).
CNT_W, $clog2(DEPTH+1), width of depth_count (derived; do not override).

Ports:
clock  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset.
enable  input  1  command qualifier; when low, no state changes.
update_mode  input  4  command code, see Behaviour.
alu_negative, alu_zero, alu_carry, alu_overflow  input  1 each  ALU flags.
bs_negative, bs_zero, bs_carry  input  1 each  barrel-shifter flags.
trap_mode  input  MODE_W  mode entered on a trap.
wr_data  input  4+MODE_W  masked-write data, bit order {N,Z,C,V,mode}.
wr_mask  input  4+MODE_W  per-bit write enable for masked write.
negative_flag, zero_flag, carry_flag, overflow_flag  output  1 each  registered flags.
mode  output  MODE_W  current mode.
is_bios  output  1  high until the first trap; restored on return.
depth_count  output  CNT_W  number of occupied stack entries.
stack_full  output  1  depth_count == DEPTH.
stack_empty  output  1  depth_count == 0.
stack_fault  output  1  sticky overflow/underflow indicator.
trap_count  output  8  see Optional Feature.

Behaviour:
- Reset (reset==0 at posedge):
  - Flags, mode, depth_count, stack_fault and trap_count go to 0; is_bios goes to 1.
  - Stack contents need not be cleared.
  - Reset has priority over every command, including one in progress.
- All outputs are registered. A command sampled at posedge k is visible after posedge k. Single-cycle; no busy state.
- Commands act only when enable==1:
  - 0: no-op.
  - 1 BS: {N,Z,C} <= bs flags; V unchanged.
  - 2 ADD: {N,Z,C,V} <= alu flags.
  - 3 MOV: {N,Z} <= alu flags.
  - 4: V <= alu_overflow.
  - 5 TRAP (not full):
    - Push {N,Z,C,V,mode,is_bios} to stack[depth_count]; depth_count+1.
    - mode <= trap_mode; is_bios <= 0; flags unchanged.
  - 5 TRAP (full):
    - No push, stack unchanged; stack_fault <= 1.
    - mode <= trap_mode and is_bios <= 0 still apply.
  - 6 RETURN (not empty): depth_count-1; {flags,mode,is_bios} <= stack[depth_count-1].
  - 6 RETURN (empty): no state change except stack_fault <= 1.
  - 7 WRITE: for each bit i with wr_mask[i]=1, {flags,mode}[i] <= wr_data[i]. is_bios and the stack are unaffected.
  - 8–15: no-op (reserved).
- stack_fault clears only on reset.
- stack_full and stack_empty are derived combinationally from registered depth_count.
- Stack is LIFO; entry index = depth_count at push time. depth_count never exceeds DEPTH and never wraps below 0.
- Back-to-back TRAP/RETURN on consecutive cycles are supported. Each uses the previous cycle's state.

Optional Feature:
SPECREG_TRAP_COUNT_EN
- Defined: trap_count increments on every TRAP command, including ones that fault, and saturates at 255 (no wrap). It is cleared only by reset.
- Undefined: trap_count is tied to 8'h00 and no counter logic is synthesised. The port remains so the interface is identical.

Test Plan:
- Reset then idle: after reset low for 1 cycle, flags=0000, mode=0, is_bios=1, depth_count=0, stack_empty=1, stack_fault=0.
- Flag updates: enable=1, cmd 2 with alu NZCV=1011 -> flags 1011; cmd 1 with bs NZC=010 -> flags 0101; cmd 3 alu NZ=10 -> 1001; enable=0 cmd 2 -> unchanged.
- Nested traps, DEPTH=4, MODE_W=2:
  - flags=1100, mode=0; TRAP trap_mode=1 -> mode=1, is_bios=0, depth=1.
  - Set flags 0011; TRAP trap_mode=2 -> depth=2.
  - RETURN -> flags=0011, mode=1, is_bios=0.
  - RETURN -> flags=1100, mode=0, is_bios=1, stack_empty=1.
- Overflow: 5 consecutive TRAPs with DEPTH=4 -> depth_count=4, stack_full=1, stack_fault=1 after the 5th. Four RETURNs then restore the original state exactly.
- Underflow + masked write: RETURN on empty -> stack_fault=1, other state unchanged. cmd 7 wr_data=6'b1111_10, wr_mask=6'b0100_11 -> Z=1, mode=2, N/C/V unchanged.
- Reset mid-stack plus counter: after 3 TRAPs, assert reset -> depth_count=0, is_bios=1, trap_count=0. With SPECREG_TRAP_COUNT_EN, 300 TRAPs -> trap_count=255; without it, trap_count=0.
